// File: rtl/ex_8_8_pkg.sv
// rtl/ex_8_8_pkg.sv - shared sizes, constants and state type for the ex_8_8 ones blocks
package ex_8_8_pkg;

  // Width of the generated word (shift register R1)
  localparam int r1_size = 8;
  // Width of the count input (down-counter R2)
  localparam int r2_size = 4;

  localparam logic PWR = 1'b1;
  localparam logic GND = 1'b0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ones_gen_state_t;

  // Thermometer code with n ones, right-aligned, saturating at the word width
  function automatic logic [r1_size-1:0] thermo(input int unsigned n);
    logic [r1_size-1:0] t;
    t = '0;
    for (int i = 0; i < r1_size; i++) begin
      if (i < n) t[i] = PWR;
    end
    return t;
  endfunction

endpackage

// File: rtl/ex_8_8_ones_gen_ctrl.sv
// rtl/ex_8_8_ones_gen_ctrl.sv - controller for the ones generator: state, rdy/done, load/shift strobes
module ones_gen_ctrl
  import ex_8_8_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic start,
  input  logic r2_zero,
  output logic rdy,
  output logic done,
  output logic load,
  output logic shift
);

  ones_gen_state_t state;

  // Ready is a pure decode of the state so the handshake has no extra lag
  assign rdy   = (state == S_IDLE);
  // A start seen while idle loads the datapath on the same edge it is sampled
  assign load  = (state == S_IDLE) && start;
  // One shift per edge while ones remain to be generated
  assign shift = (state == S_RUN) && !r2_zero;

  // State register with registered done pulse on the edge that returns to idle
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
      done  <= GND;
    end else begin
      done <= GND;
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (r2_zero) begin
            state <= S_IDLE;
            done  <= PWR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_8_8_ones_gen.sv
// rtl/ex_8_8_ones_gen.sv - serial thermometer-code generator, optional ovf flag via ONES_GEN_OVF_EN
module ex_8_8_ones_gen
  import ex_8_8_pkg::*;
#(
  parameter int W_DATA = r1_size,
  parameter int W_CNT  = r2_size
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [W_CNT-1:0]  count_in,
  output logic [W_DATA-1:0] word,
`ifdef ONES_GEN_OVF_EN
  output logic              ovf,
`endif
  output logic              rdy,
  output logic              done
);

  logic [W_CNT-1:0] r2;
  logic             r2_zero;
  logic             load;
  logic             shift;

  assign r2_zero = (r2 == '0);

  ones_gen_ctrl u_ctrl (
    .clk     (clk),
    .rstb    (rstb),
    .start   (start),
    .r2_zero (r2_zero),
    .rdy     (rdy),
    .done    (done),
    .load    (load),
    .shift   (shift)
  );

  // R1 shifts a one in from the right each run cycle; once full it stays all-ones
  always_ff @(posedge clk) begin
    if (!rstb) begin
      word <= '0;
    end else if (load) begin
      word <= '0;
    end else if (shift) begin
      word <= {word[W_DATA-2:0], PWR};
    end
  end

  // R2 counts the remaining ones; shift is only asserted when it is non-zero, so it never wraps
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r2 <= '0;
    end else if (load) begin
      r2 <= count_in;
    end else if (shift) begin
      r2 <= r2 - 1'b1;
    end
  end

`ifdef ONES_GEN_OVF_EN
  // Sticky overflow: a shift while the MSB is already set means the count exceeded the width
  always_ff @(posedge clk) begin
    if (!rstb) begin
      ovf <= GND;
    end else if (load) begin
      ovf <= GND;
    end else if (shift && word[W_DATA-1]) begin
      ovf <= PWR;
    end
  end
`endif

endmodule

// File: tb/tb_ex_8_8_ones_gen.sv
// tb/tb_ex_8_8_ones_gen.sv - self-checking bench for ex_8_8_ones_gen
module tb_ex_8_8_ones_gen;

  logic       clk;
  logic       rstb;
  logic       start;
  logic [3:0] count_in;
  logic [7:0] word;
  logic       rdy;
  logic       done;
`ifdef ONES_GEN_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] cnt;
    logic [7:0] exp_word;
    logic       exp_ovf;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] exp_word;
    logic       exp_ovf;
  } exp_t;

  exp_t sb_q[$];

  ex_8_8_ones_gen dut (
    .clk      (clk),
    .rstb     (rstb),
    .start    (start),
    .count_in (count_in),
    .word     (word),
`ifdef ONES_GEN_OVF_EN
    .ovf      (ovf),
`endif
    .rdy      (rdy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a one-cycle start and record what the run should produce
  task automatic launch(input logic [3:0] c, input logic [7:0] ew, input logic eo);
    exp_t e;
    start    = 1'b1;
    count_in = c;
    e.exp_word = ew;
    e.exp_ovf  = eo;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for rdy to return (bounded), then check latency, done pulse and scoreboard entry
  task automatic finish_run(input string nm, input int exp_lat, input int already);
    int   n;
    exp_t e;
    n = already;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, exp_lat);
    check({nm, " done high"}, {31'd0, done}, 32'd1);
    if (sb_q.size() == 0) begin
      check({nm, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({nm, " word"}, {24'd0, word}, {24'd0, e.exp_word});
`ifdef ONES_GEN_OVF_EN
      check({nm, " ovf"}, {31'd0, ovf}, {31'd0, e.exp_ovf});
`endif
    end
    @(negedge clk);
    check({nm, " done one cycle"}, {31'd0, done}, 32'd0);
    check({nm, " word held"}, {24'd0, word}, {24'd0, e.exp_word});
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd5,  8'h1F, 1'b0, 7};
    vecs[1] = '{4'd0,  8'h00, 1'b0, 2};
    vecs[2] = '{4'd8,  8'hFF, 1'b0, 10};
    vecs[3] = '{4'd12, 8'hFF, 1'b1, 14};
    vecs[4] = '{4'd1,  8'h01, 1'b0, 3};
    vecs[5] = '{4'd15, 8'hFF, 1'b1, 17};
    vecs[6] = '{4'd7,  8'h7F, 1'b0, 9};
    vecs[7] = '{4'd9,  8'hFF, 1'b1, 11};

    rstb = 1'b0;
    start = 1'b1;
    count_in = 4'd9;
    repeat (3) @(negedge clk);
    check("reset word", {24'd0, word}, 32'd0);
    check("reset rdy", {31'd0, rdy}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
`ifdef ONES_GEN_OVF_EN
    check("reset ovf", {31'd0, ovf}, 32'd0);
`endif
    rstb = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle hold rdy", {31'd0, rdy}, 32'd1);

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].cnt, vecs[i].exp_word, vecs[i].exp_ovf);
      finish_run($sformatf("vec%0d", i), vecs[i].exp_lat, 1);
    end

    // Start pulsed mid-run is ignored
    launch(4'd6, 8'h3F, 1'b0);
    @(negedge clk);
    start = 1'b1;
    count_in = 4'd3;
    @(negedge clk);
    start = 1'b0;
    finish_run("ignore mid start", 8, 3);

    // Reset on the third shift edge of a count_in=7 run
    start = 1'b1;
    count_in = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check("abort word", {24'd0, word}, 32'd0);
    check("abort rdy", {31'd0, rdy}, 32'd1);
    check("abort done", {31'd0, done}, 32'd0);
    launch(4'd2, 8'h03, 1'b0);
    finish_run("after abort", 4, 1);

    // Back-to-back: start held high reloads on the edge done drops
    start = 1'b1;
    count_in = 4'd2;
    begin
      exp_t e;
      int   n;
      e.exp_word = 8'h03;
      e.exp_ovf  = 1'b0;
      sb_q.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rdy && n < 40);
      check("b2b first latency", n, 4);
      check("b2b first done", {31'd0, done}, 32'd1);
      e = sb_q.pop_front();
      check("b2b first word", {24'd0, word}, {24'd0, e.exp_word});
      count_in = 4'd3;
      @(negedge clk);
      check("b2b reload rdy", {31'd0, rdy}, 32'd0);
      check("b2b reload done", {31'd0, done}, 32'd0);
      start = 1'b0;
      e.exp_word = 8'h07;
      sb_q.push_back(e);
      finish_run("b2b second", 5, 1);
    end

    // Loop-back: the word's population count must equal the requested count
    for (int n = 0; n <= 8; n++) begin
      launch(n[3:0], thermo_ref(n), 1'b0);
      finish_run($sformatf("loop%0d", n), n + 2, 1);
      check($sformatf("loop%0d count", n), $countones(word), n);
    end

    check("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [7:0] thermo_ref(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
